// File: rtl/cb_config_shadow.sv
// cb_config_shadow: shift-chain staging register with atomic commit to a registered config bus.
// Optional macro CB_CONF_READBACK_EN lets capture_in reload staging from conf_out for readback.
module cb_config_shadow #(
  parameter int CONF_WIDTH = 320,
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cen,
  input  logic [LANES-1:0]      shift_in,
  output logic [LANES-1:0]      shift_out,
  input  logic                  set_in,
  input  logic                  capture_in,
  output logic [CONF_WIDTH-1:0] conf_out,
  output logic                  loaded,
  output logic                  commit_ack,
  output logic                  err
);
  localparam int CHUNKS = (CONF_WIDTH + LANES - 1) / LANES;
  localparam int SW = CHUNKS * LANES;
  localparam int CW = $clog2(CHUNKS + 1);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_count, w_count_n;
  logic [SW-1:0] r_stage, w_stage_n;
  logic [CONF_WIDTH-1:0] r_conf;
  logic r_ack, r_err;
  logic [SW+LANES-1:0] w_ext;
  logic w_commit, w_bad_set, w_cap, w_bad_cap, w_shift;
  assign w_ext = {shift_in, r_stage};
  assign w_commit = set_in && r_state == FULL;
  assign w_bad_set = set_in && r_state != FULL;
`ifdef CB_CONF_READBACK_EN
  assign w_cap = capture_in && !set_in && r_state != FILLING;
  assign w_bad_cap = capture_in && !set_in && r_state == FILLING;
`else
  assign w_cap = 1'b0 & capture_in;
  assign w_bad_cap = 1'b0;
`endif
  // commit and capture both freeze the shifter for the cycle
  assign w_shift = cen && !w_commit && !w_cap;
  always_comb begin
    w_count_n = w_commit ? '0 : w_cap ? CW'(CHUNKS) :
                (w_shift && r_count != CW'(CHUNKS)) ? r_count + 1'b1 : r_count;
    w_state_n = w_count_n == '0 ? EMPTY : w_count_n == CW'(CHUNKS) ? FULL : FILLING;
    w_stage_n = w_cap ? SW'(r_conf) : w_shift ? w_ext[SW+LANES-1:LANES] : r_stage;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_count <= '0;
      r_stage <= '0;
      r_conf <= '0;
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_count <= w_count_n;
      r_stage <= w_stage_n;
      r_conf <= w_commit ? r_stage[CONF_WIDTH-1:0] : r_conf;
      r_ack <= w_commit;
      r_err <= r_err | w_bad_set | w_bad_cap;
    end
  end
  assign shift_out = r_stage[LANES-1:0];
  assign conf_out = r_conf;
  assign loaded = r_state == FULL;
  assign commit_ack = r_ack;
  assign err = r_err;
endmodule

// File: tb/tb_cb_config_shadow.sv
// tb_cb_config_shadow: directed checks of cb_config_shadow at 8-bit and 7-bit (padded) widths, LANES=2.
module tb_cb_config_shadow;
  logic clk = 1'b0;
  logic rst, cen, set_in, capture_in;
  logic [1:0] shift_in, so8, so7;
  logic [7:0] conf8;
  logic [6:0] conf7;
  logic ld8, ld7, ack8, ack7, err8, err7;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q8[$];
  logic [6:0] q7[$];

  always #5 clk = ~clk;

  cb_config_shadow #(.CONF_WIDTH(8), .LANES(2)) u8 (
    .clk(clk), .rst(rst), .cen(cen), .shift_in(shift_in), .shift_out(so8),
    .set_in(set_in), .capture_in(capture_in), .conf_out(conf8), .loaded(ld8),
    .commit_ack(ack8), .err(err8));

  cb_config_shadow #(.CONF_WIDTH(7), .LANES(2)) u7 (
    .clk(clk), .rst(rst), .cen(cen), .shift_in(shift_in), .shift_out(so7),
    .set_in(set_in), .capture_in(capture_in), .conf_out(conf7), .loaded(ld7),
    .commit_ack(ack7), .err(err7));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic c, input logic [1:0] d, input logic s);
    cen = c; shift_in = d; set_in = s;
    @(posedge clk); #1;
    cen = 1'b0; set_in = 1'b0;
  endtask

  task automatic commit(input logic c, input logic [1:0] d, input logic [7:0] e8, input logic [6:0] e7);
    int n;
    q8.push_back(e8);
    q7.push_back(e7);
    step(c, d, 1'b1);
    n = 0;
    while (!ack8 && n < 4) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_latency", n, 0);
    chk("ack7", ack7, 1);
    chk("loaded_after_commit", ld8, 0);
    chk("conf8", conf8, q8.pop_front());
    chk("conf7", conf7, q7.pop_front());
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cen = 1'b1; set_in = 1'b1; capture_in = 1'b1; shift_in = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_conf", conf8, 0);
    chk("rst_loaded", ld8, 0);
    chk("rst_ack", ack8, 0);
    chk("rst_err", err8, 0);
    chk("rst_so", so8, 0);
    rst = 1'b0; cen = 1'b0; set_in = 1'b0; capture_in = 1'b0;
    // early commit: err set, cen honoured in the same cycle
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    step(1, 2'b11, 1);
    chk("early_err", err8, 1);
    chk("early_conf", conf8, 0);
    chk("early_loaded", ld8, 0);
    chk("early_ack", ack8, 0);
    step(1, 2'b00, 0);
    chk("full_loaded", ld8, 1);
    chk("full_loaded7", ld7, 1);
    chk("full_so", so8, 2'b01);
    commit(0, 2'b00, 8'b00111001, 7'b0111001);
    step(0, 2'b00, 0);
    chk("ack_pulse_end", ack8, 0);
    chk("err_sticky", err8, 1);
    // pad bit set, then pass-through in FULL, then commit racing a shift
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    step(1, 2'b11, 0);
    chk("filling_conf_hold", conf8, 8'h39);
    step(1, 2'b10, 0);
    chk("pad_loaded", ld8, 1);
    chk("pad_so", so8, 2'b01);
    step(1, 2'b11, 0);
    chk("pass_loaded", ld8, 1);
    chk("pass_so", so8, 2'b10);
    chk("pass_conf_hold", conf8, 8'h39);
    commit(1, 2'b00, 8'hEE, 7'h6E);
    chk("unshifted_so", so8, 2'b10);
    step(1, 2'b00, 0);
    chk("post_commit_shift", so8, 2'b11);
    // reset mid-load
    step(1, 2'b11, 0);
    step(1, 2'b11, 0);
    rst = 1'b1;
    step(1, 2'b11, 1);
    rst = 1'b0;
    chk("midrst_conf", conf8, 0);
    chk("midrst_err", err8, 0);
    chk("midrst_loaded", ld8, 0);
    chk("midrst_so", so8, 0);
    step(1, 2'b01, 0);
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    chk("midrst_3_loaded", ld8, 0);
    step(1, 2'b10, 0);
    chk("midrst_4_loaded", ld8, 1);
`ifdef CB_CONF_READBACK_EN
    commit(0, 2'b00, 8'hA5, 7'h25);
    capture_in = 1'b1;
    step(0, 2'b00, 0);
    capture_in = 1'b0;
    chk("rb_loaded", ld8, 1);
    chk("rb_so0", so8, 2'b01);
    step(1, 2'b00, 0);
    chk("rb_so1", so8, 2'b01);
    step(1, 2'b00, 0);
    chk("rb_so2", so8, 2'b10);
    step(1, 2'b00, 0);
    chk("rb_so3", so8, 2'b10);
    step(1, 2'b00, 0);
`else
    capture_in = 1'b1;
    step(0, 2'b00, 0);
    capture_in = 1'b0;
    chk("cap_ignored_so", so8, 2'b01);
    chk("cap_ignored_err", err8, 0);
`endif
    chk("queue_drained", q8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
